// File: rtl/rd_pipe_ctrl.sv
// Destination-register pipeline (EXE -> MEM -> WB) for operand forwarding and register-file write.
// Owns the load-pending and load-use interlocks so unavailable load data is never marked valid.
module rd_pipe_ctrl #(
    parameter int XLEN = 32,
    parameter int RIDX = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exe_valid,
    input  logic [RIDX-1:0] exe_rd_idx,
    input  logic            exe_rd_en,
    input  logic [XLEN-1:0] exe_rd_data,
    input  logic            exe_is_load,
    input  logic [RIDX-1:0] exe_rs1_idx,
    input  logic            exe_rs1_en,
    input  logic [RIDX-1:0] exe_rs2_idx,
    input  logic            exe_rs2_en,
    input  logic            exe_flush,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_valid,
    output logic [RIDX-1:0] mem_rd_idx,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_rd_data,
    output logic [RIDX-1:0] wb_rd_idx,
    output logic            wb_rd_en,
    output logic [XLEN-1:0] wb_rd_data,
    output logic            stall_exe,
    output logic [CNTW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ALU,
        S_LD_WAIT
    } mem_state_e;

    mem_state_e      state_q, state_d;
    logic [RIDX-1:0] mem_idx_q, mem_idx_d;
    logic            mem_en_q, mem_en_d;
    logic [XLEN-1:0] mem_data_q, mem_data_d;
    logic            wb_en_q, wb_en_d;
    logic [RIDX-1:0] wb_idx_q, wb_idx_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall, load_use, capture, rs1_hit, rs2_hit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        mem_idx_d   = mem_idx_q;
        mem_en_d    = mem_en_q;
        mem_data_d  = mem_data_q;
        wb_en_d     = wb_en_q;
        wb_idx_d    = wb_idx_q;
        wb_data_d   = wb_data_q;
        stall_cnt_d = stall_cnt_q;

        rs1_hit   = exe_rs1_en && (exe_rs1_idx == mem_idx_q);
        rs2_hit   = exe_rs2_en && (exe_rs2_idx == mem_idx_q);
        mem_stall = (state_q == S_LD_WAIT) && !ld_valid;
        // Checked even on the ld_valid cycle: the load only reaches WB next cycle.
        load_use  = (state_q == S_LD_WAIT) && mem_en_q && (rs1_hit || rs2_hit);
        stall_exe = exe_valid && (mem_stall || load_use);
        capture   = exe_valid && !exe_flush && !stall_exe;

        if (mem_stall) begin
            wb_en_d = 1'b0;
        end else begin
            wb_en_d   = (state_q != S_EMPTY) && mem_en_q;
            wb_idx_d  = mem_idx_q;
            wb_data_d = (state_q == S_LD_WAIT) ? ld_data : mem_data_q;
            if (capture) begin
                state_d    = exe_is_load ? S_LD_WAIT : S_ALU;
                mem_idx_d  = exe_rd_idx;
                mem_en_d   = exe_rd_en && (exe_rd_idx != '0);
                mem_data_d = exe_rd_data;
            end else begin
                state_d  = S_EMPTY;
                mem_en_d = 1'b0;
            end
        end

        if (stall_exe && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            mem_idx_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_data_q  <= '0;
            wb_en_q     <= 1'b0;
            wb_idx_q    <= '0;
            wb_data_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_idx_q   <= mem_idx_d;
            mem_en_q    <= mem_en_d;
            mem_data_q  <= mem_data_d;
            wb_en_q     <= wb_en_d;
            wb_idx_q    <= wb_idx_d;
            wb_data_q   <= wb_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Load data is never forwarded from MEM; it becomes visible only in WB.
    assign mem_rd_idx  = mem_idx_q;
    assign mem_rd_en   = (state_q == S_ALU) && mem_en_q;
    assign mem_rd_data = mem_data_q;
    assign wb_rd_idx   = wb_idx_q;
    assign wb_rd_en    = wb_en_q;
    assign wb_rd_data  = wb_data_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_rd_pipe_ctrl.sv
// Directed bench for rd_pipe_ctrl: expected WB writes are queued at stimulus time and
// popped as the DUT retires them; stage outputs and interlocks are checked in place.
module tb_rd_pipe_ctrl;

    localparam int XLEN = 32;
    localparam int RIDX = 5;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            exe_valid;
    logic [RIDX-1:0] exe_rd_idx;
    logic            exe_rd_en;
    logic [XLEN-1:0] exe_rd_data;
    logic            exe_is_load;
    logic [RIDX-1:0] exe_rs1_idx;
    logic            exe_rs1_en;
    logic [RIDX-1:0] exe_rs2_idx;
    logic            exe_rs2_en;
    logic            exe_flush;
    logic [XLEN-1:0] ld_data;
    logic            ld_valid;
    logic [RIDX-1:0] mem_rd_idx;
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_rd_data;
    logic [RIDX-1:0] wb_rd_idx;
    logic            wb_rd_en;
    logic [XLEN-1:0] wb_rd_data;
    logic            stall_exe;
    logic [CNTW-1:0] stall_cnt;

    rd_pipe_ctrl #(.XLEN(XLEN), .RIDX(RIDX), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .exe_valid   (exe_valid),
        .exe_rd_idx  (exe_rd_idx),
        .exe_rd_en   (exe_rd_en),
        .exe_rd_data (exe_rd_data),
        .exe_is_load (exe_is_load),
        .exe_rs1_idx (exe_rs1_idx),
        .exe_rs1_en  (exe_rs1_en),
        .exe_rs2_idx (exe_rs2_idx),
        .exe_rs2_en  (exe_rs2_en),
        .exe_flush   (exe_flush),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .mem_rd_idx  (mem_rd_idx),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .wb_rd_idx   (wb_rd_idx),
        .wb_rd_en    (wb_rd_en),
        .wb_rd_data  (wb_rd_data),
        .stall_exe   (stall_exe),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RIDX-1:0] idx;
        logic [XLEN-1:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then retire any WB write against the scoreboard.
    task automatic tick();
        wb_exp_t e;
        @(posedge clk);
        #1;
        if (wb_rd_en !== 1'b0) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_write", {59'd0, wb_rd_en}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("wb_idx", 64'(wb_rd_idx), 64'(e.idx));
                check("wb_data", 64'(wb_rd_data), 64'(e.data));
            end
        end
    endtask

    task automatic idle();
        exe_valid   = 1'b0;
        exe_rd_idx  = '0;
        exe_rd_en   = 1'b0;
        exe_rd_data = '0;
        exe_is_load = 1'b0;
        exe_rs1_idx = '0;
        exe_rs1_en  = 1'b0;
        exe_rs2_idx = '0;
        exe_rs2_en  = 1'b0;
        exe_flush   = 1'b0;
        ld_valid    = 1'b0;
        ld_data     = '0;
    endtask

    task automatic drive(input logic [RIDX-1:0] rd, input logic [XLEN-1:0] data, input logic is_load,
                         input logic [RIDX-1:0] rs1, input logic rs1_en,
                         input logic [RIDX-1:0] rs2, input logic rs2_en);
        exe_valid   = 1'b1;
        exe_rd_idx  = rd;
        exe_rd_en   = 1'b1;
        exe_rd_data = data;
        exe_is_load = is_load;
        exe_rs1_idx = rs1;
        exe_rs1_en  = rs1_en;
        exe_rs2_idx = rs2;
        exe_rs2_en  = rs2_en;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        do_reset();
        #1;
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_wb_rd_en", 64'(wb_rd_en), 64'd0);
        check("rst_stall_exe", 64'(stall_exe), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Reset while a load waits; the late ld_valid must be ignored.
        drive(5'd3, '0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(5'd12, 32'h12, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        #1;
        check("t1_stall_in_ldwait", 64'(stall_exe), 64'd1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD0003;
        #1;
        check("t1_stall_after_rst", 64'(stall_exe), 64'd0);
        tick();
        idle();
        check("t1_wb_rd_en", 64'(wb_rd_en), 64'd0);
        check("t1_mem_rd_en", 64'(mem_rd_en), 64'd0);
        tick();
        check("t1_wb_rd_en_late", 64'(wb_rd_en), 64'd0);

        // ALU x5 latency: MEM after 1 cycle, WB after 2.
        drive(5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{idx: 5'd5, data: 32'h1234});
        tick();
        idle();
        check("t2_mem_rd_en", 64'(mem_rd_en), 64'd1);
        check("t2_mem_rd_idx", 64'(mem_rd_idx), 64'd5);
        check("t2_mem_rd_data", 64'(mem_rd_data), 64'h1234);
        check("t2_wb_rd_en_c1", 64'(wb_rd_en), 64'd0);
        tick();
        check("t2_wb_rd_en_c2", 64'(wb_rd_en), 64'd1);
        check("t2_mem_rd_en_c2", 64'(mem_rd_en), 64'd0);

        // Load x7, independent reader of x8, ld_valid after 3 wait cycles.
        do_reset();
        drive(5'd7, '0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{idx: 5'd7, data: 32'hCAFE0007});
        tick();
        drive(5'd9, 32'h99, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        #1;
        check("t3_mem_rd_en_ldwait", 64'(mem_rd_en), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_wait", 64'(stall_exe), 64'd1);
            tick();
            check("t3_wb_bubble", 64'(wb_rd_en), 64'd0);
        end
        ld_valid = 1'b1;
        ld_data  = 32'hCAFE0007;
        #1;
        check("t3_stall_on_ldvalid", 64'(stall_exe), 64'd0);
        sb.push_back('{idx: 5'd9, data: 32'h99});
        tick();
        idle();
        check("t3_wb_rd_en", 64'(wb_rd_en), 64'd1);
        check("t3_mem_rd_en", 64'(mem_rd_en), 64'd1);
        check("t3_mem_rd_idx", 64'(mem_rd_idx), 64'd9);
        check("t3_stall_cnt", 64'(stall_cnt), 64'd3);
        tick();

        // Load-use on x7 with ld_valid in the first wait cycle.
        do_reset();
        drive(5'd7, '0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(5'd10, 32'hA, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        ld_valid = 1'b1;
        ld_data  = 32'h7777;
        sb.push_back('{idx: 5'd7, data: 32'h7777});
        #1;
        check("t4_stall_load_use", 64'(stall_exe), 64'd1);
        tick();
        ld_valid = 1'b0;
        ld_data  = '0;
        #1;
        check("t4_stall_released", 64'(stall_exe), 64'd0);
        check("t4_mem_bubble", 64'(mem_rd_en), 64'd0);
        check("t4_wb_rd_en", 64'(wb_rd_en), 64'd1);
        check("t4_wb_rd_idx", 64'(wb_rd_idx), 64'd7);
        sb.push_back('{idx: 5'd10, data: 32'hA});
        tick();
        idle();
        check("t4_mem_rd_en", 64'(mem_rd_en), 64'd1);
        check("t4_mem_rd_idx", 64'(mem_rd_idx), 64'd10);
        check("t4_stall_cnt", 64'(stall_cnt), 64'd1);
        tick();

        // Writes to x0 are never published.
        drive(5'd0, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        idle();
        check("t5_mem_rd_en", 64'(mem_rd_en), 64'd0);
        tick();
        check("t5_wb_rd_en", 64'(wb_rd_en), 64'd0);
        tick();

        // Flush during LD_WAIT: the load completes, the flushed instruction vanishes.
        drive(5'd4, '0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{idx: 5'd4, data: 32'h4444});
        tick();
        drive(5'd11, 32'hBAD, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        exe_flush = 1'b1;
        #1;
        check("t6_stall_with_flush", 64'(stall_exe), 64'd1);
        tick();
        check("t6_mem_hidden", 64'(mem_rd_en), 64'd0);
        ld_valid = 1'b1;
        ld_data  = 32'h4444;
        tick();
        idle();
        check("t6_wb_rd_en", 64'(wb_rd_en), 64'd1);
        check("t6_mem_rd_en", 64'(mem_rd_en), 64'd0);
        tick();
        check("t6_mem_rd_en_after", 64'(mem_rd_en), 64'd0);
        check("t6_wb_rd_en_after", 64'(wb_rd_en), 64'd0);

        // Stall counter saturates instead of wrapping.
        do_reset();
        drive(5'd2, '0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        sb.push_back('{idx: 5'd2, data: 32'h2222});
        tick();
        idle();
        #1;
        check("t7_no_stall_when_idle", 64'(stall_exe), 64'd0);
        drive(5'd13, 32'h13, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        exe_rd_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t7_stall_cnt_sat", 64'(stall_cnt), 64'd7);
        ld_valid = 1'b1;
        ld_data  = 32'h2222;
        tick();
        idle();
        tick();
        tick();
        check("t7_stall_cnt_hold", 64'(stall_cnt), 64'd7);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
